// File: rtl/pic_pkg.sv
// Shared types and decode constants for the PIC command sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ICW2,
        ST_ICW3,
        ST_ICW4,
        ST_READY
    } pic_state_e;

    localparam logic [1:0] RD_IRR  = 2'd0;
    localparam logic [1:0] RD_ISR  = 2'd1;
    localparam logic [1:0] RD_IMR  = 2'd2;
    localparam logic [1:0] RD_POLL = 2'd3;

    localparam int ICW1_BIT = 4;
    localparam int OCW_SEL_HI = 4;
    localparam int OCW_SEL_LO = 3;
    localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
    localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;
    localparam int RIS_BIT = 0;
    localparam int RR_BIT  = 1;
    localparam int P_BIT   = 2;

    // With RR clear the read-register selection bits are kept from the old word.
    function automatic logic [7:0] merge_ocw3(input logic [7:0] old_word,
                                              input logic [7:0] new_word,
                                              input logic       poll_en);
        logic [7:0] r;
        r = new_word;
        if (!new_word[RR_BIT]) r[RR_BIT:RIS_BIT] = old_word[RR_BIT:RIS_BIT];
        if (!poll_en) r[P_BIT] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/pic_strobe_sync.sv
// Synchronises the asynchronous CPU bus strobes and detects their edges;
// a0/din/cs are captured on the write falling edge.
module pic_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       wr_rise,
    output logic       rd_fall,
    output logic       rd_a0,
    output logic       cap_cs,
    output logic       cap_a0,
    output logic [7:0] cap_din
);

    logic [SYNC_STAGES-1:0] cs_sync, wr_sync, rd_sync;
    logic wr_d, rd_d;
    logic wr_fall;

    // Idle-high reset values so no edge is seen coming out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync <= '1;
            wr_sync <= '1;
            rd_sync <= '1;
            wr_d    <= 1'b1;
            rd_d    <= 1'b1;
            cap_cs  <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr_n};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], rd_n};
            wr_d    <= wr_sync[SYNC_STAGES-1];
            rd_d    <= rd_sync[SYNC_STAGES-1];
            if (wr_fall) cap_cs <= ~cs_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fall) begin
            cap_a0  <= a0;
            cap_din <= din;
        end
    end

    assign wr_fall = wr_d & ~wr_sync[SYNC_STAGES-1];
    assign wr_rise = ~wr_d & wr_sync[SYNC_STAGES-1];
    assign rd_fall = rd_d & ~rd_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES-1];
    assign rd_a0   = a0;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// PIC initialisation / operation command sequencer (ICW1..4, OCW1..3).
// Define PIC_POLL_EN to enable the OCW3 poll command.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] IMR_RST = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs_n,
    input  logic               wr_n,
    input  logic               rd_n,
    input  logic               a0,
    input  logic [7:0]         din,
    output logic [7:0]         icw1,
    output logic [7:0]         icw2,
    output logic [NUM_IRQ-1:0] icw3,
    output logic [7:0]         icw4,
    output logic [NUM_IRQ-1:0] ocw1,
    output logic [7:0]         ocw2,
    output logic [7:0]         ocw3,
    output logic               init_done,
    output logic               ocw2_stb,
    output logic               rd_stb,
    output logic [1:0]         rd_sel
);

    localparam int NB = NUM_IRQ / 8;
`ifdef PIC_POLL_EN
    localparam logic POLL_EN = 1'b1;
`else
    localparam logic POLL_EN = 1'b0;
`endif

    logic       wr_rise, rd_fall, rd_a0, cap_cs, cap_a0;
    logic [7:0] cap_din;
    logic       wr_commit, is_icw1, last_byte, ptr;
    pic_state_e state, state_nxt, after_icw3;

    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs_n    (cs_n),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .a0      (a0),
        .din     (din),
        .wr_rise (wr_rise),
        .rd_fall (rd_fall),
        .rd_a0   (rd_a0),
        .cap_cs  (cap_cs),
        .cap_a0  (cap_a0),
        .cap_din (cap_din)
    );

    assign wr_commit  = wr_rise & cap_cs;
    assign is_icw1    = wr_commit & ~cap_a0 & cap_din[ICW1_BIT];
    assign last_byte  = (int'(ptr) == NB - 1);
    assign after_icw3 = icw1[0] ? ST_ICW4 : ST_READY;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (is_icw1) begin
            state_nxt = ST_ICW2;
        end else if (wr_commit && cap_a0) begin
            case (state)
                ST_ICW2: state_nxt = !icw1[1] ? ST_ICW3 : after_icw3;
                ST_ICW3: if (last_byte) state_nxt = after_icw3;
                ST_ICW4: state_nxt = ST_READY;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        init_done = (state == ST_READY);
    end

    // Command registers; ICW1 outranks every other decode so re-init is clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icw1     <= '0;
            icw2     <= '0;
            icw3     <= '0;
            icw4     <= '0;
            ocw1     <= IMR_RST;
            ocw2     <= '0;
            ocw3     <= 8'h02;
            ptr      <= 1'b0;
            ocw2_stb <= 1'b0;
            rd_stb   <= 1'b0;
            rd_sel   <= RD_IRR;
        end else begin
            ocw2_stb <= 1'b0;
            rd_stb   <= 1'b0;
            if (is_icw1) begin
                icw1 <= cap_din;
                icw4 <= '0;
                ocw1 <= '0;
                ocw3 <= 8'h02;
                ptr  <= 1'b0;
            end else if (wr_commit) begin
                case (state)
                    ST_ICW2: if (cap_a0) icw2 <= cap_din;
                    ST_ICW3: if (cap_a0) begin
                        for (int b = 0; b < NB; b++)
                            if (int'(ptr) == b) icw3[b*8 +: 8] <= cap_din;
                        ptr <= last_byte ? 1'b0 : ptr + 1'b1;
                    end
                    ST_ICW4: if (cap_a0) icw4 <= cap_din;
                    ST_READY: if (cap_a0) begin
                        for (int b = 0; b < NB; b++)
                            if (int'(ptr) == b) ocw1[b*8 +: 8] <= cap_din;
                        ptr <= last_byte ? 1'b0 : ptr + 1'b1;
                    end else begin
                        ptr <= 1'b0;
                        if (cap_din[OCW_SEL_HI:OCW_SEL_LO] == OCW_SEL_OCW2) begin
                            ocw2     <= cap_din;
                            ocw2_stb <= 1'b1;
                        end else if (cap_din[OCW_SEL_HI:OCW_SEL_LO] == OCW_SEL_OCW3) begin
                            ocw3 <= merge_ocw3(ocw3, cap_din, POLL_EN);
                        end
                    end
                    default: ;
                endcase
            end
            // A read colliding with a committed write is dropped.
            if (rd_fall && !wr_commit) begin
                rd_stb <= 1'b1;
                if (rd_a0) begin
                    rd_sel <= RD_IMR;
                end else if (ocw3[P_BIT]) begin
                    rd_sel       <= RD_POLL;
                    ocw3[P_BIT]  <= 1'b0;
                end else begin
                    rd_sel <= ocw3[RIS_BIT] ? RD_ISR : RD_IRR;
                end
            end
        end
    end

endmodule
